trig_scheduler: RTL
===================

# trig_scheduler

Shot sequencer for the ultrasonic pulser/acquisition chain, running in the 100 MHz domain. It picks the trigger source for each shot: the internal PRF timer, the conditioned external trigger from the external-trigger conditioner, or a software strobe. For each accepted trigger it fires the pulser and starts the ADC acquisition, then waits for acquisition completion and enforces a holdoff. It runs single bursts or continuous operation, and counts shots and triggers that were lost because the chain was busy.

## Interface
Parameters:
- PERIOD_W, 24, width of internal PRF period (10 ns units)
- CNT_W, 16, width of shot/missed counters

Ports:
- i_clk100M  in  1  100 MHz clock
- i_rst_n  in  1  asynchronous active-low reset
- i_arm  in  1  1-cycle pulse; start burst from IDLE
- i_abort  in  1  1-cycle pulse; return to IDLE from any state
- i_mode  in  2  0 internal PRF, 1 external, 2 software, 3 reserved (no triggers accepted)
- i_sw_trig  in  1  1-cycle software trigger
- i_ext_trig  in  1  conditioned external trigger (multi-cycle high pulse, synchronous to i_clk100M)
- i_period  in  PERIOD_W  internal PRF period, cycles
- i_holdoff  in  16  post-acquisition dead time, cycles
- i_pulse_w  in  8  o_fire width, cycles
- i_burst  in  8  shots per arm; 0 = continuous
- i_acq_done  in  1  1-cycle pulse from acquisition block
- o_fire  out  1  pulser drive
- o_acq_start  out  1  1-cycle acquisition start
- o_busy  out  1  high in every state except IDLE
- o_burst_done  out  1  1-cycle pulse when burst completes
- o_shot_cnt  out  CNT_W  shots fired since last arm
- o_missed  out  CNT_W  triggers dropped since last arm

## Operation
States (one-hot): IDLE, WAIT_TRIG, FIRE, ACQ, HOLDOFF.
- IDLE: on i_arm, load the remaining-shot counter from i_burst, clear o_shot_cnt and o_missed, then go to WAIT_TRIG.
- WAIT_TRIG: a trigger event moves to FIRE. Trigger event by mode:
  - mode 0: PRF tick;
  - mode 1: rising edge of i_ext_trig (registered previous value);
  - mode 2: i_sw_trig.
- FIRE: o_fire high for max(i_pulse_w,1) cycles. o_acq_start is asserted in the first FIRE cycle only. o_shot_cnt increments once (saturating). Then go to ACQ.
- ACQ: wait for i_acq_done. i_acq_done is ignored in every other state.
- HOLDOFF: count i_holdoff cycles. With i_holdoff=0, ACQ goes directly to the next state. On exit:
  - i_burst=0: go to WAIT_TRIG;
  - otherwise decrement the remaining-shot counter; if it reaches 0, pulse o_burst_done and go to IDLE, else go to WAIT_TRIG.
- Missed trigger: a trigger event in FIRE, ACQ or HOLDOFF increments o_missed (saturating). It is not queued.
- PRF timer:
  - free-runs while o_busy and mode 0;
  - tick every max(i_period,2) cycles;
  - restarts from zero on i_arm.
- i_abort: next cycle state=IDLE and o_fire=0. Counters hold. No o_burst_done. i_abort wins over a simultaneous i_arm.
- i_arm outside IDLE is ignored.
- i_mode and i_period changes take effect on the next event. i_burst and i_pulse_w are sampled at arm and FIRE entry respectively.

## Timing
- Reset: state IDLE; o_fire, o_acq_start, o_busy, o_burst_done = 0; o_shot_cnt = o_missed = 0; PRF counter 0.
- Trigger event in cycle N (WAIT_TRIG): o_fire and o_acq_start high in cycle N+1.
- o_fire falls after exactly max(i_pulse_w,1) cycles. ACQ is entered the cycle after the last o_fire cycle.
- i_acq_done in cycle M: HOLDOFF spans M+1..M+i_holdoff. The next trigger is accepted from cycle M+i_holdoff+1.
- o_burst_done is asserted in the cycle the state returns to IDLE. o_busy drops in the same cycle.
- All outputs are registered. No combinational input-to-output paths.

## Configuration
- TRIG_MISS_CNT_EN defined: o_missed counts as specified.
- TRIG_MISS_CNT_EN undefined: the missed counter logic is absent, o_missed is tied to 0, and dropped triggers are discarded silently. All other behaviour is identical.

## Structure
- Package trig_sched_pkg holds:
  - one-hot state localparams;
  - mode constants MODE_INT, MODE_EXT, MODE_SW;
  - the minimum period constant 2.
- Sub-module trig_prf_timer: period counter with restart, enable and 1-cycle tick output. Instanced once.

## Test plan
- Mode 0, i_period=1000, i_burst=3, i_pulse_w=5, i_holdoff=0, acq_done 50 cycles after start -> 3 fires spaced 1000 cycles, each 5 cycles wide; o_shot_cnt=3; o_burst_done once; o_busy low after.
- Mode 1, i_ext_trig held high 3 cycles at cycle 100 -> exactly one o_acq_start at cycle 101. A second edge during ACQ -> o_missed=1 with the macro defined, 0 without it.
- Mode 2, i_holdoff=200, i_sw_trig pulses 150 and 250 cycles after i_acq_done -> first is missed, second fires. o_shot_cnt=2 (with the initial shot).
- i_burst=0, mode 0, i_period=0 -> tick every 2 cycles; continuous shots until i_abort. o_fire drops the next cycle; no o_burst_done.
- i_abort and i_arm in the same cycle during ACQ -> IDLE; counters unchanged. A later i_arm clears the counters.
- i_rst_n asserted mid-FIRE -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/trig_sched_pkg.sv
// Shared types and constants for the ultrasonic shot sequencer.
package trig_sched_pkg;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_WAIT = 5'b00010,
    ST_FIRE = 5'b00100,
    ST_ACQ  = 5'b01000,
    ST_HOLD = 5'b10000
  } state_t;

  localparam logic [1:0] MODE_INT = 2'd0;
  localparam logic [1:0] MODE_EXT = 2'd1;
  localparam logic [1:0] MODE_SW  = 2'd2;

  localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/trig_prf_timer.sv
// Internal PRF period counter: registered 1-cycle tick every max(period,2) enabled cycles.
module trig_prf_timer
  import trig_sched_pkg::*;
#(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         restart,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] cnt;
  logic [W-1:0] limit;

  always_comb begin
    limit = (period < W'(MIN_PERIOD)) ? W'(MIN_PERIOD - 1) : period - W'(1);
  end

  // >= rather than == so a period shortened mid-count still wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (cnt >= limit) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + W'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/trig_scheduler.sv
// Shot sequencer: trigger select, pulser fire, acquisition wait, holdoff, burst/continuous.
// Build option TRIG_MISS_CNT_EN enables the dropped-trigger counter on o_missed.
module trig_scheduler
  import trig_sched_pkg::*;
#(
  parameter int unsigned PERIOD_W = 24,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                i_clk100M,
  input  logic                i_rst_n,
  input  logic                i_arm,
  input  logic                i_abort,
  input  logic [1:0]          i_mode,
  input  logic                i_sw_trig,
  input  logic                i_ext_trig,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic [15:0]         i_holdoff,
  input  logic [7:0]          i_pulse_w,
  input  logic [7:0]          i_burst,
  input  logic                i_acq_done,
  output logic                o_fire,
  output logic                o_acq_start,
  output logic                o_busy,
  output logic                o_burst_done,
  output logic [CNT_W-1:0]    o_shot_cnt,
  output logic [CNT_W-1:0]    o_missed
);

  state_t      state, state_nxt;
  logic        ext_prev, prf_tick, trig_evt;
  logic        arm_go, fire_go, leave_dead, burst_end;
  logic        continuous;
  logic [7:0]  shots_left, pw_cnt;
  logic [15:0] hold_cnt;

  trig_prf_timer #(.W(PERIOD_W)) u_prf (
    .clk     (i_clk100M),
    .rst_n   (i_rst_n),
    .restart (arm_go),
    .en      (o_busy && (i_mode == MODE_INT)),
    .period  (i_period),
    .tick    (prf_tick)
  );

  always_comb begin
    case (i_mode)
      MODE_INT: trig_evt = prf_tick;
      MODE_EXT: trig_evt = i_ext_trig & ~ext_prev;
      MODE_SW:  trig_evt = i_sw_trig;
      default:  trig_evt = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk100M or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    arm_go     = 1'b0;
    fire_go    = 1'b0;
    leave_dead = 1'b0;
    burst_end  = 1'b0;
    case (state)
      ST_IDLE: if (i_arm) begin
        arm_go    = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: if (trig_evt) begin
        fire_go   = 1'b1;
        state_nxt = ST_FIRE;
      end
      ST_FIRE: if (pw_cnt <= 8'd1) state_nxt = ST_ACQ;
      ST_ACQ:  if (i_acq_done) begin
        if (i_holdoff == '0) leave_dead = 1'b1;
        else                 state_nxt  = ST_HOLD;
      end
      ST_HOLD: if (hold_cnt <= 16'd1) leave_dead = 1'b1;
      default: state_nxt = ST_IDLE;
    endcase
    // Zero holdoff shares the HOLDOFF exit path straight from ACQ.
    if (leave_dead) begin
      if (!continuous && shots_left <= 8'd1) begin
        burst_end = 1'b1;
        state_nxt = ST_IDLE;
      end else begin
        state_nxt = ST_WAIT;
      end
    end
    if (i_abort) begin
      state_nxt  = ST_IDLE;
      arm_go     = 1'b0;
      fire_go    = 1'b0;
      leave_dead = 1'b0;
      burst_end  = 1'b0;
    end
  end

  // Outputs are registered from the next-state decode so they align with the state.
  always_ff @(posedge i_clk100M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ext_prev     <= 1'b0;
      o_fire       <= 1'b0;
      o_acq_start  <= 1'b0;
      o_busy       <= 1'b0;
      o_burst_done <= 1'b0;
      o_shot_cnt   <= '0;
      shots_left   <= '0;
      continuous   <= 1'b0;
      pw_cnt       <= '0;
      hold_cnt     <= '0;
    end else begin
      ext_prev     <= i_ext_trig;
      o_fire       <= (state_nxt == ST_FIRE);
      o_acq_start  <= fire_go;
      o_busy       <= (state_nxt != ST_IDLE);
      o_burst_done <= burst_end;
      if (arm_go) begin
        shots_left <= i_burst;
        continuous <= (i_burst == '0);
        o_shot_cnt <= '0;
      end else begin
        if (fire_go && o_shot_cnt != '1) o_shot_cnt <= o_shot_cnt + CNT_W'(1);
        if (leave_dead && !continuous)   shots_left <= shots_left - 8'd1;
      end
      if (fire_go)               pw_cnt <= (i_pulse_w == '0) ? 8'd1 : i_pulse_w;
      else if (state == ST_FIRE) pw_cnt <= pw_cnt - 8'd1;
      if (state == ST_ACQ)       hold_cnt <= i_holdoff;
      else if (state == ST_HOLD) hold_cnt <= hold_cnt - 16'd1;
    end
  end

`ifdef TRIG_MISS_CNT_EN
  logic miss_evt;

  always_comb begin
    miss_evt = trig_evt && !i_abort && (state inside {ST_FIRE, ST_ACQ, ST_HOLD});
  end

  always_ff @(posedge i_clk100M or negedge i_rst_n) begin
    if (!i_rst_n)                        o_missed <= '0;
    else if (arm_go)                     o_missed <= '0;
    else if (miss_evt && o_missed != '1) o_missed <= o_missed + CNT_W'(1);
  end
`else
  assign o_missed = '0;
`endif

endmodule
